// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

    localparam int BR_STAGE_EX  = 2;
    localparam int BR_STAGE_MEM = 3;
    localparam int REG_ZERO     = 0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - three saturating event counters for stall, flush and freeze cycles
module hazard_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_stall,
    input  logic             inc_flush,
    input  logic             inc_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] freeze_q, freeze_d;

    always_comb begin
        stall_d  = stall_q;
        flush_d  = flush_q;
        freeze_d = freeze_q;
        if (inc_stall && stall_q != CNT_MAX) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (inc_flush && flush_q != CNT_MAX) begin
            flush_d = flush_q + CNT_W'(1);
        end
        if (inc_freeze && freeze_q != CNT_MAX) begin
            freeze_d = freeze_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else begin
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            freeze_q <= freeze_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign freeze_cnt = freeze_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use/branch/freeze hazard controller; HAZARD_PERF_CNT_EN builds perf counters
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW           = 5,
    parameter int LOAD_USE_STALL   = 1,
    parameter int BR_RESOLVE_STAGE = 2,
    parameter int CNT_W            = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              exmem_mem_read,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              br_taken,
    input  logic              dmem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              exmem_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              stall_active,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt,
    output logic [CNT_W-1:0]  perf_freeze_cnt
);

    localparam logic [2:0]        N_EX      = 3'(LOAD_USE_STALL);
    localparam logic [2:0]        N_MEM     = 3'(LOAD_USE_STALL - 1);
    localparam logic              MEM_HAZ   = (LOAD_USE_STALL >= 2);
    localparam logic              BR_IN_MEM = (BR_RESOLVE_STAGE == BR_STAGE_MEM);
    localparam logic [REG_AW-1:0] RZ        = REG_AW'(REG_ZERO);

    hz_state_t  st_q, st_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] stall_len;
    logic       match_ex, match_mem;
    logic       haz_ex, haz_mem;
    logic       freeze, br_flush, lu_stall;

    always_comb begin
        match_ex  = (idex_rd != RZ) && id_valid &&
                    ((id_use_rs1 && idex_rd == id_rs1) || (id_use_rs2 && idex_rd == id_rs2));
        match_mem = (exmem_rd != RZ) && id_valid &&
                    ((id_use_rs1 && exmem_rd == id_rs1) || (id_use_rs2 && exmem_rd == id_rs2));
        haz_ex    = idex_mem_read && match_ex;
        haz_mem   = exmem_mem_read && match_mem && MEM_HAZ;
        stall_len = haz_ex ? N_EX : N_MEM;
    end

    // The first stall cycle is spent in RUN; LU_STALL covers the rest.
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        freeze   = 1'b0;
        br_flush = 1'b0;
        lu_stall = 1'b0;
        if (dmem_busy) begin
            freeze = 1'b1;
        end else if (br_taken) begin
            br_flush = 1'b1;
            st_d     = RUN;
            cnt_d    = 3'd0;
        end else if (st_q == LU_STALL) begin
            lu_stall = 1'b1;
            if (cnt_q <= 3'd1) begin
                st_d  = RUN;
                cnt_d = 3'd0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (haz_ex || haz_mem) begin
            lu_stall = 1'b1;
            if (stall_len > 3'd1) begin
                st_d  = LU_STALL;
                cnt_d = stall_len - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= RUN;
            cnt_q <= 3'd0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        stall_active = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            stall_active = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            stall_active = 1'b1;
        end else if (br_flush) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = BR_IN_MEM;
        end else if (lu_stall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_flush   = 1'b1;
            stall_active = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .inc_stall (lu_stall),
        .inc_flush (br_flush),
        .inc_freeze(freeze),
        .stall_cnt (perf_stall_cnt),
        .flush_cnt (perf_flush_cnt),
        .freeze_cnt(perf_freeze_cnt)
    );
`else
    assign perf_stall_cnt  = '0;
    assign perf_flush_cnt  = '0;
    assign perf_freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench over three controller configurations
module tb_pipeline_hazard_ctrl;

    localparam int NDUT = 3;
    localparam int CW   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs1, id_use_rs2;
    logic [4:0] id_rs1, id_rs2, idex_rd, exmem_rd;
    logic       idex_mem_read, exmem_mem_read, br_taken, dmem_busy;

    logic [NDUT-1:0][7:0]    obs;
    logic [NDUT-1:0][CW-1:0] ps, pf, pz;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rem    [NDUT];
    int n_stall[NDUT];
    int n_flush[NDUT];
    int n_frz  [NDUT];

    always #5 clk = ~clk;

    // dut 0: 1 bubble, EX branches; dut 1: 3 bubbles, EX; dut 2: 3 bubbles, MEM branches
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pipeline_hazard_ctrl #(
            .REG_AW          (5),
            .LOAD_USE_STALL  ((g == 0) ? 1 : 3),
            .BR_RESOLVE_STAGE((g == 2) ? 3 : 2),
            .CNT_W           (CW)
        ) dut (
            .clk            (clk),
            .rst            (rst),
            .id_valid       (id_valid),
            .id_rs1         (id_rs1),
            .id_rs2         (id_rs2),
            .id_use_rs1     (id_use_rs1),
            .id_use_rs2     (id_use_rs2),
            .idex_mem_read  (idex_mem_read),
            .idex_rd        (idex_rd),
            .exmem_mem_read (exmem_mem_read),
            .exmem_rd       (exmem_rd),
            .br_taken       (br_taken),
            .dmem_busy      (dmem_busy),
            .pc_write       (obs[g][7]),
            .ifid_write     (obs[g][6]),
            .idex_write     (obs[g][5]),
            .exmem_write    (obs[g][4]),
            .ifid_flush     (obs[g][3]),
            .idex_flush     (obs[g][2]),
            .exmem_flush    (obs[g][1]),
            .stall_active   (obs[g][0]),
            .perf_stall_cnt (ps[g]),
            .perf_flush_cnt (pf[g]),
            .perf_freeze_cnt(pz[g])
        );
    end

    function automatic int lus(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit reads(input logic [4:0] rd);
        return rd != 0 && id_valid &&
               ((id_use_rs1 && rd == id_rs1) || (id_use_rs2 && rd == id_rs2));
    endfunction

    function automatic int exp_cnt(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic idle();
        id_valid = 1'b1; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0; exmem_rd = 5'd0;
        idex_mem_read = 1'b0; exmem_mem_read = 1'b0;
        br_taken = 1'b0; dmem_busy = 1'b0; rst = 1'b0;
    endtask

    task automatic load_use_ex();
        idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    // Checks every instance against the model for the current inputs, then clocks once.
    task automatic cycle();
        logic [7:0] expv;
        bit hx, hm;
        int n;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            hx = idex_mem_read && reads(idex_rd);
            hm = exmem_mem_read && reads(exmem_rd) && lus(i) >= 2;
            if (rst) begin
                expv = 8'b0000_1111;
            end else if (dmem_busy) begin
                expv = 8'b0000_0001;
            end else if (br_taken) begin
                expv = (i == 2) ? 8'b1111_1110 : 8'b1111_1100;
            end else if (rem[i] > 0 || hx || hm) begin
                expv = 8'b0011_0101;
            end else begin
                expv = 8'b1111_0000;
            end
            checks++;
            assert (obs[i] === expv) else begin
                errors++;
                $error("FAIL ctl%0d cyc%0d observed %b expected %b", i, cyc, obs[i], expv);
            end
            checks++;
            assert ({ps[i], pf[i], pz[i]} ===
                    {CW'(exp_cnt(n_stall[i])), CW'(exp_cnt(n_flush[i])), CW'(exp_cnt(n_frz[i]))}) else begin
                errors++;
                $error("FAIL perf%0d cyc%0d observed %0d/%0d/%0d expected %0d/%0d/%0d", i, cyc,
                       ps[i], pf[i], pz[i], exp_cnt(n_stall[i]), exp_cnt(n_flush[i]), exp_cnt(n_frz[i]));
            end
            if (rst) begin
                rem[i] = 0; n_stall[i] = 0; n_flush[i] = 0; n_frz[i] = 0;
            end else if (dmem_busy) begin
                n_frz[i]++;
            end else if (br_taken) begin
                n_flush[i]++; rem[i] = 0;
            end else if (rem[i] > 0) begin
                n_stall[i]++; rem[i]--;
            end else if (hx || hm) begin
                n = hx ? lus(i) : lus(i) - 1;
                n_stall[i]++; rem[i] = n - 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rem[i] = 0; n_stall[i] = 0; n_flush[i] = 0; n_frz[i] = 0;
        end
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        load_use_ex();
        cycle();
        idle();
        repeat (4) cycle();

        exmem_mem_read = 1'b1; exmem_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        cycle();
        idle();
        repeat (3) cycle();

        load_use_ex();
        cycle();
        idle();
        br_taken = 1'b1;
        cycle();
        br_taken = 1'b0;
        repeat (2) cycle();

        load_use_ex();
        cycle();
        idle();
        dmem_busy = 1'b1;
        repeat (4) cycle();
        dmem_busy = 1'b0;
        repeat (3) cycle();

        idex_mem_read = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cycle();
        load_use_ex();
        id_valid = 1'b0;
        cycle();
        id_valid = 1'b1; id_use_rs1 = 1'b0;
        cycle();
        idle();

        load_use_ex();
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        load_use_ex();
        repeat (5) cycle();
        idle();
        br_taken = 1'b1;
        repeat (4) cycle();
        dmem_busy = 1'b1;
        repeat (4) cycle();
        idle();
        cycle();

        repeat (600) begin
            rst            = ($urandom_range(0, 59) == 0);
            dmem_busy      = ($urandom_range(0, 6) == 0);
            br_taken       = ($urandom_range(0, 9) == 0);
            id_valid       = ($urandom_range(0, 7) != 0);
            id_use_rs1     = $urandom_range(0, 1);
            id_use_rs2     = $urandom_range(0, 1);
            id_rs1         = 5'($urandom_range(0, 3));
            id_rs2         = 5'($urandom_range(0, 3));
            idex_rd        = 5'($urandom_range(0, 3));
            exmem_rd       = 5'($urandom_range(0, 3));
            idex_mem_read  = ($urandom_range(0, 2) == 0);
            exmem_mem_read = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
